pulse_packetiser: RTL and testbench
===================================

# pulse_packetiser

- Captures one range line of ADC samples per radar pulse and emits it as a PACKET stream into the radar processor's input queue.
- Sits directly upstream of the processor: its output drives the processor's PACKET input.
- Each line runs from a programmable start delay after the pulse trigger and lasts `Length` samples.
- Also counts pulses per Doppler frame and missed triggers.

## Interface
Parameters:
- `Width`, 14, ADC sample width.
- `Length`, 2500, samples per range line.
- `PulsesPerFrame`, 128, pulses per Doppler frame; must be a power of two.
- `DelayWidth`, 16, width of the start-delay register.

Ports:
- `ipClk`  in  1  system clock; the only clock in the block.
- `ipReset`  in  1  reset, synchronous and active-low.
- `ipEnable`  in  1  arms capture; sampled only in IDLE.
- `ipDelay`  in  DelayWidth  start delay in ADC samples; latched on the accepted trigger.
- `ipTrigger`  in  1  pulse trigger level, already synchronous to `ipClk`; the rising edge is the event.
- `ipADC_Data`  in  Width  ADC sample.
- `ipADC_Valid`  in  1  sample strobe.
- `opPacket`  out  PACKET  fields `SoP`, `EoP`, `Data[Width-1:0]`, `Valid`; no backpressure.
- `opBusy`  out  1  high in DELAY or CAPTURE.
- `opPulseCount`  out  log2(PulsesPerFrame)  index of the next line within the frame.
- `opFrameDone`  out  1  one-cycle pulse.
- `opMissedTriggers`  out  16  saturating count of ignored trigger edges.

## Operation
- Edge detect: `Edge = ipTrigger & ~Trigger_d`, where `Trigger_d` is registered. `Trigger_d` resets to 1, so a trigger held high through reset gives no edge.
- States: IDLE, DELAY, CAPTURE.
- IDLE:
  - On `Edge & ipEnable`: latch `ipDelay` into `DelayCount`.
  - Go to DELAY if the latched delay is non-zero, otherwise to CAPTURE.
  - `Edge` with `ipEnable` low: ignored, not counted as missed.
- DELAY: each `ipADC_Valid` decrements `DelayCount`. The strobe that takes it to 0 is discarded, and the state moves to CAPTURE.
- CAPTURE:
  - Each `ipADC_Valid` emits one output beat and increments `SampleCount` (0..Length-1).
  - `SoP` is asserted on sample 0; `EoP` on sample Length-1.
  - After `EoP`, return to IDLE.
  - `SampleCount` wraps to 0 at the end of every line.
- Missed trigger: any `Edge` while in DELAY or CAPTURE increments `opMissedTriggers`, which saturates at 0xFFFF. This includes an edge in the cycle the EoP sample is accepted.
- `ipEnable` falling mid-line: the current line completes; packets are never truncated except by reset.
- Pulse count: increments on each EoP and wraps from PulsesPerFrame-1 to 0. `opFrameDone` asserts in the same cycle as the EoP beat of line PulsesPerFrame-1.
- Width rules:
  - `Data` is `ipADC_Data` unmodified.
  - `SampleCount` is `$clog2(Length)` bits.
  - `DelayCount` is DelayWidth bits.

## Timing
- Reset (`ipReset` low at a clock edge): all outputs 0 on the next cycle; state IDLE; all counters 0.
  - Reset mid-line aborts the line without EoP. This is acceptable because the downstream queue shares the reset.
- Output beats are registered; latency is 1 cycle from `ipADC_Valid` to `opPacket.Valid`.
- `SoP`, `EoP` and `Data` are valid only while `Valid` is high, and are 0 otherwise.
- Trigger edge at cycle t (IDLE, enabled): state changes at t+1. An `ipADC_Valid` in cycle t is not counted toward delay or capture.
- Delay D > 0: the first captured sample is the (D+1)th strobe after the trigger.
- `opBusy` rises at t+1 and falls the cycle after the EoP beat is output.
- Back-to-back lines: the earliest accepted edge is the cycle after the state returns to IDLE.
- Length=1: `SoP` and `EoP` assert on the same beat.

## Structure
- The shared package holds:
  - the existing PACKET typedef, with the Data width matching `Width`;
  - a new `PACKETISER_STATE` enum (IDLE, DELAY, CAPTURE).
- Edge detection, the FSM and the counters live in one module; no sub-module.
- Target: about 150–200 RTL lines.

## Test plan
The bench uses Length=8, PulsesPerFrame=4, and `ipADC_Valid` every other cycle unless stated.
- Delay=0, one trigger: 8 beats with data 0..7; SoP on data 0, EoP on data 7; `opBusy` falls 1 cycle after EoP.
- Delay=3: the first three post-trigger strobes (data 0..2) are discarded, so the packet carries data 3..10.
- Second trigger mid-CAPTURE, then a third trigger in the EoP cycle: `opMissedTriggers` = 2; a single 8-beat packet is output.
- 4 consecutive lines: `opPulseCount` steps 1, 2, 3, 0; `opFrameDone` pulses exactly with the 4th EoP.
- `ipEnable` dropped at sample 4: the line completes to EoP; the next trigger is ignored and `opMissedTriggers` is unchanged.
- Reset asserted at sample 5 with `ipTrigger` held high: all outputs 0 next cycle, no EoP; no capture after release until `ipTrigger` falls and rises again.

Source files
------------

// File: rtl/pulse_packetiser_pkg.sv
// Shared types for the radar front end: the PACKET beat format consumed by
// the processor input queue and the packetiser line-capture states.
package pulse_packetiser_pkg;

  // Data width carried by a PACKET beat; matches the ADC sample width.
  localparam int PacketWidth = 14;

  // One beat of the processor input stream. Framing bits are only meaningful
  // while Valid is high and are driven to 0 otherwise.
  typedef struct packed {
    logic                   SoP;
    logic                   EoP;
    logic [PacketWidth-1:0] Data;
    logic                   Valid;
  } PACKET;

  // Line capture progress: waiting for a trigger, skipping the start delay,
  // or forwarding samples of the range line.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2
  } PACKETISER_STATE;

  // Saturation ceiling of the missed-trigger counter.
  localparam logic [15:0] MissedMax = 16'hFFFF;

endpackage

// File: rtl/pulse_packetiser.sv
// Captures one range line of ADC samples per radar pulse trigger and emits it
// as a PACKET stream. Also tracks the pulse index within the Doppler frame and
// counts trigger edges that arrive while a line is still in progress.
module pulse_packetiser
  import pulse_packetiser_pkg::*;
#(
  parameter int Width          = 14,
  parameter int Length         = 2500,
  parameter int PulsesPerFrame = 128,
  parameter int DelayWidth     = 16,
  localparam int PulseWidth    = (PulsesPerFrame > 1) ? $clog2(PulsesPerFrame) : 1
) (
  input  logic                  ipClk,
  input  logic                  ipReset,
  input  logic                  ipEnable,
  input  logic [DelayWidth-1:0] ipDelay,
  input  logic                  ipTrigger,
  input  logic [Width-1:0]      ipADC_Data,
  input  logic                  ipADC_Valid,
  output PACKET                 opPacket,
  output logic                  opBusy,
  output logic [PulseWidth-1:0] opPulseCount,
  output logic                  opFrameDone,
  output logic [15:0]           opMissedTriggers
);

  localparam int SampleWidth = (Length > 1) ? $clog2(Length) : 1;
  localparam logic [SampleWidth-1:0] LastSample = SampleWidth'(Length - 1);
  localparam logic [PulseWidth-1:0]  LastPulse  = PulseWidth'(PulsesPerFrame - 1);

  PACKETISER_STATE        state;
  PACKETISER_STATE        stateNext;
  logic                   triggerDly;
  logic                   edgeDetect;
  logic [DelayWidth-1:0]  delayCount;
  logic [DelayWidth-1:0]  delayCountNext;
  logic [SampleWidth-1:0] sampleCount;
  logic [SampleWidth-1:0] sampleCountNext;
  logic [PulseWidth-1:0]  pulseCount;
  logic [15:0]            missedCount;
  PACKET                  packetReg;
  PACKET                  packetNext;
  logic                   frameDoneReg;
  logic                   lineEnd;

  // Rising edge of the trigger level; triggerDly resets high so a trigger
  // already high when reset is released does not start a line.
  assign edgeDetect = ipTrigger & ~triggerDly;

  // Next-state, counter and output-beat decode for the line capture FSM.
  always_comb begin
    stateNext       = state;
    delayCountNext  = delayCount;
    sampleCountNext = sampleCount;
    packetNext      = '0;
    lineEnd         = 1'b0;
    case (state)
      IDLE: begin
        if (edgeDetect && ipEnable) begin
          delayCountNext = ipDelay;
          stateNext      = (ipDelay != '0) ? DELAY : CAPTURE;
        end
      end
      DELAY: begin
        // The strobe that exhausts the delay is itself discarded.
        if (ipADC_Valid) begin
          delayCountNext = delayCount - DelayWidth'(1);
          if (delayCount == DelayWidth'(1)) begin
            stateNext = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (ipADC_Valid) begin
          packetNext.Valid = 1'b1;
          packetNext.Data  = ipADC_Data;
          packetNext.SoP   = (sampleCount == '0);
          packetNext.EoP   = (sampleCount == LastSample);
          if (sampleCount == LastSample) begin
            sampleCountNext = '0;
            lineEnd         = 1'b1;
            stateNext       = IDLE;
          end else begin
            sampleCountNext = sampleCount + SampleWidth'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, counters and the registered output beat.
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      state        <= IDLE;
      triggerDly   <= 1'b1;
      delayCount   <= '0;
      sampleCount  <= '0;
      pulseCount   <= '0;
      missedCount  <= '0;
      packetReg    <= '0;
      frameDoneReg <= 1'b0;
    end else begin
      state        <= stateNext;
      triggerDly   <= ipTrigger;
      delayCount   <= delayCountNext;
      sampleCount  <= sampleCountNext;
      packetReg    <= packetNext;
      frameDoneReg <= lineEnd && (pulseCount == LastPulse);
      if (lineEnd) begin
        pulseCount <= pulseCount + PulseWidth'(1);
      end
      // Any edge while a line is in flight is dropped, including one in the
      // same cycle as the EoP sample.
      if (edgeDetect && (state != IDLE) && (missedCount != MissedMax)) begin
        missedCount <= missedCount + 16'd1;
      end
    end
  end

  // Busy stays high through the cycle that presents the EoP beat.
  assign opBusy           = (state != IDLE) | (packetReg.Valid & packetReg.EoP);
  assign opPacket         = packetReg;
  assign opPulseCount     = pulseCount;
  assign opFrameDone      = frameDoneReg;
  assign opMissedTriggers = missedCount;

endmodule

// File: tb/tb_pulse_packetiser.sv
// Bench for pulse_packetiser: directed line scenarios followed by randomized
// traffic, all checked every cycle against a line-level model.
module tb_pulse_packetiser;
  import pulse_packetiser_pkg::*;

  localparam int W   = 14;
  localparam int LEN = 8;
  localparam int PPF = 4;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          en = 1'b1;
  logic [DW-1:0] dly = '0;
  logic          trig = 1'b0;
  logic [W-1:0]  adc = '0;
  logic          adcValid = 1'b0;
  PACKET         pkt;
  logic          busy;
  logic [1:0]    pcount;
  logic          fdone;
  logic [15:0]   missedOut;

  pulse_packetiser #(
    .Width(W), .Length(LEN), .PulsesPerFrame(PPF), .DelayWidth(DW)
  ) dut (
    .ipClk(clk), .ipReset(rstN), .ipEnable(en), .ipDelay(dly),
    .ipTrigger(trig), .ipADC_Data(adc), .ipADC_Valid(adcValid),
    .opPacket(pkt), .opBusy(busy), .opPulseCount(pcount),
    .opFrameDone(fdone), .opMissedTriggers(missedOut)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // Line-level model state.
  int mInLine = 0, mSkip = 0, mTaken = 0, mPulses = 0, mMissed = 0, mPrevTrig = 1;
  int eValid, eSop, eEop, eData, eBusy, eFrame;

  // Observation log for the directed scenarios.
  int beats[$];
  int sopCnt, eopCnt, frameCnt, frameBad, frameAtEop, eopCyc, fallCyc;
  int prevBusyObs = 0;
  int pcs[4];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic clearLog();
    beats.delete();
    sopCnt = 0; eopCnt = 0; frameCnt = 0; frameBad = 0; frameAtEop = -1;
    eopCyc = -100; fallCyc = -1;
  endtask

  // Advance one clock: predict outputs from the current inputs, clock, compare.
  task automatic cyc();
    int edgeSeen;
    eValid = 0; eSop = 0; eEop = 0; eData = 0; eFrame = 0;
    if (!rstN) begin
      mInLine = 0; mSkip = 0; mTaken = 0; mPulses = 0; mMissed = 0; mPrevTrig = 1;
    end else begin
      edgeSeen = (trig && !mPrevTrig) ? 1 : 0;
      if (mInLine == 0) begin
        if (edgeSeen != 0 && en) begin
          mInLine = 1; mSkip = int'(dly); mTaken = 0;
        end
      end else begin
        if (edgeSeen != 0 && mMissed < 65535) mMissed++;
        if (adcValid) begin
          if (mSkip > 0) mSkip--;
          else begin
            eValid = 1;
            eSop   = (mTaken == 0) ? 1 : 0;
            eEop   = (mTaken == LEN - 1) ? 1 : 0;
            eData  = int'(adc);
            mTaken++;
            if (eEop != 0) begin
              mInLine = 0;
              mPulses = (mPulses + 1) % PPF;
              eFrame  = (mPulses == 0) ? 1 : 0;
            end
          end
        end
      end
      mPrevTrig = trig ? 1 : 0;
    end
    eBusy = (mInLine != 0 || eEop != 0) ? 1 : 0;

    @(posedge clk);
    #1;
    cycle++;
    check("valid", int'(pkt.Valid), eValid);
    check("sop", int'(pkt.SoP), eSop);
    check("eop", int'(pkt.EoP), eEop);
    check("data", int'(pkt.Data), eData);
    check("busy", int'(busy), eBusy);
    check("pulse_count", int'(pcount), mPulses);
    check("frame_done", int'(fdone), eFrame);
    check("missed", int'(missedOut), mMissed);

    if (pkt.Valid) beats.push_back(int'(pkt.Data));
    if (pkt.Valid && pkt.SoP) sopCnt++;
    if (pkt.Valid && pkt.EoP) begin eopCnt++; eopCyc = cycle; end
    if (fdone) begin
      frameCnt++;
      frameAtEop = eopCnt;
      if (!(pkt.Valid && pkt.EoP)) frameBad++;
    end
    if (prevBusyObs != 0 && !busy) fallCyc = cycle;
    prevBusyObs = busy ? 1 : 0;
  endtask

  task automatic idle(input int n);
    adcValid = 1'b0; adc = '0;
    repeat (n) cyc();
  endtask

  // One ADC strobe followed by a quiet cycle (strobe every other cycle).
  task automatic strobe(input int d);
    adcValid = 1'b1; adc = W'(d); cyc();
    adcValid = 1'b0; adc = '0; cyc();
  endtask

  task automatic trigger(input int d);
    dly = DW'(d); trig = 1'b1; adcValid = 1'b0; cyc();
    trig = 1'b0;
  endtask

  initial begin
    clearLog();
    rstN = 1'b0; idle(2);
    check("reset_pkt", int'(pkt), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_missed", int'(missedOut), 0);
    rstN = 1'b1; idle(2);

    // Delay 0: data 0..7, busy falls one cycle after the EoP beat.
    clearLog(); trigger(0);
    for (int i = 0; i < 8; i++) strobe(i);
    idle(3);
    check("s1_beats", beats.size(), 8);
    for (int i = 0; i < 8; i++) check("s1_data", beats[i], i);
    check("s1_sop", sopCnt, 1);
    check("s1_eop", eopCnt, 1);
    check("s1_busy_fall", fallCyc - eopCyc, 1);
    check("s1_pulse", int'(pcount), 1);

    // Delay 3: first three strobes discarded, packet carries 3..10.
    clearLog(); trigger(3);
    for (int i = 0; i < 11; i++) strobe(i);
    idle(3);
    check("s2_beats", beats.size(), 8);
    for (int i = 0; i < 8; i++) check("s2_data", beats[i], i + 3);
    check("s2_pulse", int'(pcount), 2);

    // Extra triggers mid-capture and in the EoP cycle are both missed.
    clearLog(); trigger(0);
    for (int i = 0; i < 8; i++) begin
      trig = (i == 3 || i == 7); adcValid = 1'b1; adc = W'(i); cyc();
      trig = 1'b0; adcValid = 1'b0; adc = '0; cyc();
    end
    idle(3);
    check("s3_missed", int'(missedOut), 2);
    check("s3_beats", beats.size(), 8);
    check("s3_sop", sopCnt, 1);
    check("s3_eop", eopCnt, 1);

    // Four lines after reset: pulse count 1,2,3,0 and one frame-done pulse.
    rstN = 1'b0; idle(2);
    check("s4_reset_missed", int'(missedOut), 0);
    check("s4_reset_pulse", int'(pcount), 0);
    rstN = 1'b1; idle(2);
    clearLog();
    for (int l = 0; l < 4; l++) begin
      trigger(l);
      for (int i = 0; i < 8 + l; i++) strobe(100 + i);
      idle(2);
      pcs[l] = int'(pcount);
    end
    check("s4_pc0", pcs[0], 1);
    check("s4_pc1", pcs[1], 2);
    check("s4_pc2", pcs[2], 3);
    check("s4_pc3", pcs[3], 0);
    check("s4_frames", frameCnt, 1);
    check("s4_frame_on_eop", frameBad, 0);
    check("s4_frame_at", frameAtEop, 4);

    // Enable dropped at sample 4: line completes; next trigger ignored.
    clearLog(); en = 1'b1; trigger(0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) en = 1'b0;
      strobe(i);
    end
    idle(2);
    trigger(0);
    for (int i = 0; i < 8; i++) strobe(50 + i);
    idle(2);
    check("s5_beats", beats.size(), 8);
    check("s5_eop", eopCnt, 1);
    check("s5_missed", int'(missedOut), 0);
    check("s5_pulse", int'(pcount), 1);
    en = 1'b1;

    // Reset at sample 5 with trigger held high.
    clearLog(); dly = '0; trig = 1'b1; adcValid = 1'b0; cyc();
    for (int i = 0; i < 5; i++) strobe(i);
    rstN = 1'b0; adcValid = 1'b1; adc = W'(5); cyc();
    check("s6_rst_pkt", int'(pkt), 0);
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_pulse", int'(pcount), 0);
    check("s6_rst_frame", int'(fdone), 0);
    rstN = 1'b1; adcValid = 1'b0; adc = '0; cyc();
    for (int i = 0; i < 8; i++) strobe(20 + i);
    idle(2);
    check("s6_no_capture", beats.size(), 5);
    check("s6_no_eop", eopCnt, 0);
    trig = 1'b0; cyc();
    trigger(0);
    for (int i = 0; i < 8; i++) strobe(30 + i);
    idle(2);
    check("s6_recapture", beats.size(), 13);
    check("s6_eop", eopCnt, 1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      rstN     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) trig = ~trig;
      en       = ($urandom_range(0, 9) != 0);
      dly      = DW'($urandom_range(0, 4));
      adcValid = ($urandom_range(0, 1) != 0);
      adc      = W'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
